// File: rtl/cali_pkg.sv
// Shared widths, CSR map and arithmetic helpers for the calibration apply block.
package cali_pkg;

  localparam int unsigned NCh    = 320;
  localparam int unsigned DataW  = 16;
  localparam int unsigned CoefW  = 16;
  localparam int unsigned FracW  = 14;
  localparam int unsigned ChW    = 9;
  localparam int unsigned AddrW  = ChW + 1;
  localparam int unsigned ProdW  = DataW + CoefW;
  localparam int unsigned RndW   = ProdW + 1 - FracW;

  localparam logic [ChW-1:0] CsrCtrl   = ChW'(0);
  localparam logic [ChW-1:0] CsrStatus = ChW'(1);

  localparam int unsigned CtrlSwapBit   = 0;
  localparam int unsigned CtrlBypassBit = 1;
  localparam int unsigned CtrlClrErrBit = 2;

  localparam int unsigned StActiveBit  = 0;
  localparam int unsigned StPendingBit = 1;
  localparam int unsigned StBypassBit  = 2;
  localparam int unsigned StErrBit     = 3;

  typedef enum logic [1:0] {
    RdZero,
    RdRam,
    RdCsr
  } rd_sel_e;

  // Adds the sign-extended offset to the rounded product and clamps to the sample range.
  function automatic logic signed [DataW-1:0] sat_add(input logic signed [RndW-1:0]  a,
                                                      input logic signed [CoefW-1:0] b);
    logic signed [RndW:0] s;
    s = (RndW+1)'(a) + (RndW+1)'(b);
    if (!s[RndW] && (|s[RndW-1:DataW-1])) return {1'b0, {(DataW-1){1'b1}}};
    if (s[RndW] && !(&s[RndW-1:DataW-1])) return {1'b1, {(DataW-1){1'b0}}};
    return s[DataW-1:0];
  endfunction

endpackage

// File: rtl/cali_ram_dp.sv
// True-dual-port coefficient RAM: port A read/write with byte enables, port B read-only.
module cali_ram_dp #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned Depth = 1 << AddrW
) (
  input  logic             clk_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic             a_we_i,
  input  logic [3:0]       a_be_i,
  input  logic [31:0]      a_wdata_i,
  output logic [31:0]      a_rdata_o,
  input  logic [AddrW-1:0] b_addr_i,
  output logic [31:0]      b_rdata_o
);

  logic [31:0]      mem [Depth];
  logic [AddrW-1:0] a_addr_q;
  logic [AddrW-1:0] b_addr_q;

  always_ff @(posedge clk_i) begin
    a_addr_q <= a_addr_i;
    b_addr_q <= b_addr_i;
    if (a_we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be_i[i]) mem[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      end
    end
  end

  assign a_rdata_o = mem[a_addr_q];
  assign b_rdata_o = mem[b_addr_q];

endmodule

// File: rtl/cali_ram_apply.sv
// Double-buffered gain/offset calibration: Avalon-MM CSR/RAM slave plus a 3-stage apply pipeline.
module cali_ram_apply
  import cali_pkg::*;
#(
  parameter int unsigned NumCh = NCh
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [AddrW-1:0]        avs_address_i,
  input  logic                    avs_read_i,
  input  logic                    avs_write_i,
  input  logic [3:0]              avs_byteenable_i,
  input  logic [31:0]             avs_writedata_i,
  output logic [31:0]             avs_readdata_o,
  output logic                    avs_readdatavalid_o,
  input  logic                    snk_valid_i,
  input  logic                    snk_sop_i,
  input  logic [ChW-1:0]          snk_channel_i,
  input  logic signed [DataW-1:0] snk_data_i,
  output logic                    src_valid_o,
  output logic                    src_sop_o,
  output logic [ChW-1:0]          src_channel_o,
  output logic signed [DataW-1:0] src_data_o
);

  localparam logic [ChW-1:0] ChLimit = ChW'(NumCh);

  // Assertion is asynchronous; release is retimed to the clock.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rst_sync_q <= '0;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic           csr_sel, entry_ok, ctrl_wr;
  logic [ChW-1:0] av_idx;
  assign csr_sel  = avs_address_i[AddrW-1];
  assign av_idx   = avs_address_i[ChW-1:0];
  assign entry_ok = !csr_sel && (av_idx < ChLimit);
  assign ctrl_wr  = avs_write_i && csr_sel && (av_idx == CsrCtrl);

  logic active_q, active_d, pending_q, pending_d, bypass_q, bypass_d, err_q, err_d;
  logic swap_now, bank_eff, snk_bad;
  // A sop that consumes the pending swap already reads from the new bank.
  assign swap_now = snk_valid_i && snk_sop_i && pending_q;
  assign bank_eff = active_q ^ swap_now;
  assign snk_bad  = snk_valid_i && (snk_channel_i >= ChLimit);

  always_comb begin
    active_d  = bank_eff;
    pending_d = pending_q;
    bypass_d  = bypass_q;
    err_d     = err_q;
    if (swap_now) pending_d = 1'b0;
    else if (ctrl_wr && avs_writedata_i[CtrlSwapBit]) pending_d = 1'b1;
    if (ctrl_wr) bypass_d = avs_writedata_i[CtrlBypassBit];
    if (ctrl_wr && avs_writedata_i[CtrlClrErrBit]) err_d = 1'b0;
    if (snk_bad) err_d = 1'b1;
  end

  logic [31:0] status_word, ctrl_word;
  always_comb begin
    status_word               = '0;
    status_word[StActiveBit]  = active_q;
    status_word[StPendingBit] = pending_q;
    status_word[StBypassBit]  = bypass_q;
    status_word[StErrBit]     = err_q;
    ctrl_word                 = '0;
    ctrl_word[CtrlBypassBit]  = bypass_q;
  end

  logic [31:0] ram_a_rdata, ram_b_rdata;
  // Port A always targets the bank opposite to the one port B reads this cycle.
  cali_ram_dp #(
    .AddrW(AddrW)
  ) u_ram (
    .clk_i     (clk_i),
    .a_addr_i  ({~bank_eff, av_idx}),
    .a_we_i    (avs_write_i && entry_ok),
    .a_be_i    (avs_byteenable_i),
    .a_wdata_i (avs_writedata_i),
    .a_rdata_o (ram_a_rdata),
    .b_addr_i  ({bank_eff, snk_channel_i}),
    .b_rdata_o (ram_b_rdata)
  );

  rd_sel_e     rd_sel_d, rd_sel_q;
  logic        rd_v_q, rdvalid_q;
  logic [31:0] rd_csr_q, readdata_q, readdata_d;

  always_comb begin
    rd_sel_d = RdZero;
    if (csr_sel) rd_sel_d = ((av_idx == CsrCtrl) || (av_idx == CsrStatus)) ? RdCsr : RdZero;
    else if (entry_ok) rd_sel_d = RdRam;
    unique case (rd_sel_q)
      RdRam:   readdata_d = ram_a_rdata;
      RdCsr:   readdata_d = rd_csr_q;
      default: readdata_d = '0;
    endcase
  end

  logic                    v1_q, sop1_q, pass1_q, v2_q, sop2_q, pass2_q;
  logic [ChW-1:0]          ch1_q, ch2_q;
  logic signed [DataW-1:0] d1_q, d2_q;
  logic signed [ProdW-1:0] prod2_q;
  logic signed [CoefW-1:0] off2_q, gain;
  logic signed [ProdW:0]   prod_rnd;
  logic signed [RndW-1:0]  rnd;
  logic                    src_valid_q, src_sop_q;
  logic [ChW-1:0]          src_ch_q;
  logic signed [DataW-1:0] src_data_q;

  assign gain     = ram_b_rdata[CoefW-1:0];
  assign prod_rnd = (ProdW+1)'(prod2_q) + (ProdW+1)'(1 << (FracW - 1));
  assign rnd      = RndW'(prod_rnd >>> FracW);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      bypass_q    <= 1'b0;
      err_q       <= 1'b0;
      rd_v_q      <= 1'b0;
      rd_sel_q    <= RdZero;
      rd_csr_q    <= '0;
      rdvalid_q   <= 1'b0;
      readdata_q  <= '0;
      v1_q        <= 1'b0;
      sop1_q      <= 1'b0;
      pass1_q     <= 1'b0;
      ch1_q       <= '0;
      d1_q        <= '0;
      v2_q        <= 1'b0;
      sop2_q      <= 1'b0;
      pass2_q     <= 1'b0;
      ch2_q       <= '0;
      d2_q        <= '0;
      prod2_q     <= '0;
      off2_q      <= '0;
      src_valid_q <= 1'b0;
      src_sop_q   <= 1'b0;
      src_ch_q    <= '0;
      src_data_q  <= '0;
    end else begin
      active_q    <= active_d;
      pending_q   <= pending_d;
      bypass_q    <= bypass_d;
      err_q       <= err_d;
      rd_v_q      <= avs_read_i;
      rd_sel_q    <= rd_sel_d;
      rd_csr_q    <= (av_idx == CsrStatus) ? status_word : ctrl_word;
      rdvalid_q   <= rd_v_q;
      if (rd_v_q) readdata_q <= readdata_d;
      v1_q        <= snk_valid_i;
      sop1_q      <= snk_sop_i;
      pass1_q     <= bypass_q || snk_bad;
      ch1_q       <= snk_channel_i;
      d1_q        <= snk_data_i;
      v2_q        <= v1_q;
      sop2_q      <= sop1_q;
      pass2_q     <= pass1_q;
      ch2_q       <= ch1_q;
      d2_q        <= d1_q;
      prod2_q     <= ProdW'(d1_q) * ProdW'(gain);
      off2_q      <= ram_b_rdata[31:16];
      src_valid_q <= v2_q;
      src_sop_q   <= sop2_q;
      src_ch_q    <= ch2_q;
      if (v2_q) src_data_q <= pass2_q ? d2_q : sat_add(rnd, off2_q);
    end
  end

  assign avs_readdata_o      = readdata_q;
  assign avs_readdatavalid_o = rdvalid_q;
  assign src_valid_o         = src_valid_q;
  assign src_sop_o           = src_sop_q;
  assign src_channel_o       = src_ch_q;
  assign src_data_o          = src_data_q;

endmodule

// File: tb/tb_cali_ram_apply.sv
// Directed bench for cali_ram_apply: table-driven streaming plus swap, bypass, readback and reset cases.
module tb_cali_ram_apply;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic [9:0]         avs_address;
  logic               avs_read, avs_write;
  logic [3:0]         avs_byteenable;
  logic [31:0]        avs_writedata, avs_readdata;
  logic               avs_readdatavalid;
  logic               snk_valid, snk_sop, src_valid, src_sop;
  logic [8:0]         snk_channel, src_channel;
  logic signed [15:0] snk_data, src_data;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] CTRL   = 10'h200;
  localparam logic [9:0] STATUS = 10'h201;

  cali_ram_apply dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .avs_address_i       (avs_address),
    .avs_read_i          (avs_read),
    .avs_write_i         (avs_write),
    .avs_byteenable_i    (avs_byteenable),
    .avs_writedata_i     (avs_writedata),
    .avs_readdata_o      (avs_readdata),
    .avs_readdatavalid_o (avs_readdatavalid),
    .snk_valid_i         (snk_valid),
    .snk_sop_i           (snk_sop),
    .snk_channel_i       (snk_channel),
    .snk_data_i          (snk_data),
    .src_valid_o         (src_valid),
    .src_sop_o           (src_sop),
    .src_channel_o       (src_channel),
    .src_data_o          (src_data)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  typedef struct {
    logic [8:0]         ch;
    logic signed [15:0] data;
    logic               sop;
    logic signed [15:0] exp;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic av_wr(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] be);
    avs_address = addr; avs_writedata = data; avs_byteenable = be; avs_write = 1'b1;
    cyc();
    avs_write = 1'b0;
  endtask

  task automatic av_rd(input logic [9:0] addr, input logic [31:0] exp, input string name);
    avs_address = addr; avs_read = 1'b1;
    cyc();
    avs_read = 1'b0;
    #4 chk({name, " rdvalid early"}, {31'b0, avs_readdatavalid}, 32'd0);
    cyc();
    #4 chk({name, " rdvalid"}, {31'b0, avs_readdatavalid}, 32'd1);
    chk(name, avs_readdata, exp);
    cyc();
  endtask

  task automatic send1(input logic [8:0] ch, input logic signed [15:0] data, input logic sop,
                       input logic signed [15:0] exp, input string name);
    snk_valid = 1'b1; snk_sop = sop; snk_channel = ch; snk_data = data;
    cyc();
    snk_valid = 1'b0; snk_sop = 1'b0;
    cyc();
    #4 chk({name, " valid early"}, {31'b0, src_valid}, 32'd0);
    cyc();
    #4 chk({name, " valid"}, {31'b0, src_valid}, 32'd1);
    chk({name, " sop"}, {31'b0, src_sop}, {31'b0, sop});
    chk({name, " data"}, {16'h0, src_data}, {16'h0, exp});
    cyc();
  endtask

  initial begin
    logic stale;
    vecs[0] = '{ch: 9'd5,   data: 16'sd1000,   sop: 1'b1, exp: 16'sd1000};
    vecs[1] = '{ch: 9'd7,   data: 16'sd101,    sop: 1'b0, exp: 16'sd46};
    vecs[2] = '{ch: 9'd7,   data: -16'sd101,   sop: 1'b0, exp: -16'sd55};
    vecs[3] = '{ch: 9'd9,   data: 16'sd30000,  sop: 1'b0, exp: 16'sd32767};
    vecs[4] = '{ch: 9'd9,   data: -16'sd30000, sop: 1'b0, exp: -16'sd32768};
    vecs[5] = '{ch: 9'd5,   data: -16'sd7,     sop: 1'b0, exp: -16'sd7};
    vecs[6] = '{ch: 9'd7,   data: 16'sd0,      sop: 1'b0, exp: -16'sd5};
    vecs[7] = '{ch: 9'd320, data: 16'sd1234,   sop: 1'b0, exp: 16'sd1234};
    vecs[8] = '{ch: 9'd511, data: -16'sd2,     sop: 1'b0, exp: -16'sd2};

    rst_ni = 1'b0; avs_address = '0; avs_read = 0; avs_write = 0; avs_byteenable = '0;
    avs_writedata = '0; snk_valid = 0; snk_sop = 0; snk_channel = '0; snk_data = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset src_valid", {31'b0, src_valid}, 32'd0);
    chk("reset src_data", {16'h0, src_data}, 32'd0);
    chk("reset readdata", avs_readdata, 32'd0);
    chk("reset rdvalid", {31'b0, avs_readdatavalid}, 32'd0);
    rst_ni = 1'b1;
    repeat (3) cyc();
    av_rd(STATUS, 32'h0, "status after reset");

    // Load shadow bank 1, then request a swap that the first sop consumes.
    av_wr(10'd5,  32'h0000_4000, 4'hF);
    av_wr(10'd7,  32'hFFFB_2000, 4'hF);
    av_wr(10'd9,  32'h0000_7FFF, 4'hF);
    av_wr(CTRL, 32'h1, 4'hF);
    av_rd(STATUS, 32'h2, "status pending");

    for (int i = 0; i < NV + 3; i++) begin
      if (i < NV) begin
        snk_valid = 1'b1; snk_sop = vecs[i].sop; snk_channel = vecs[i].ch; snk_data = vecs[i].data;
      end else begin
        snk_valid = 1'b0; snk_sop = 1'b0;
      end
      #4;
      if (i >= 3) begin
        chk($sformatf("vec%0d valid", i - 3), {31'b0, src_valid}, 32'd1);
        chk($sformatf("vec%0d sop", i - 3), {31'b0, src_sop}, {31'b0, vecs[i-3].sop});
        chk($sformatf("vec%0d channel", i - 3), {23'b0, src_channel}, {23'b0, vecs[i-3].ch});
        chk($sformatf("vec%0d data", i - 3), {16'h0, src_data}, {16'h0, vecs[i-3].exp});
      end
      cyc();
    end
    av_rd(STATUS, 32'h9, "status err set");
    av_wr(CTRL, 32'h4, 4'hF);
    av_rd(STATUS, 32'h1, "status err cleared");

    // Bank 0 is now shadow: load half gain for ch5, swap only on the next sop.
    av_wr(10'd5, 32'h0000_2000, 4'hF);
    av_wr(CTRL, 32'h1, 4'hF);
    av_rd(STATUS, 32'h3, "status pending bank1");
    send1(9'd5, 16'sd1000, 1'b0, 16'sd1000, "non-sop old bank");
    send1(9'd5, 16'sd1000, 1'b1, 16'sd500, "sop new bank");
    av_rd(STATUS, 32'h0, "status swapped to bank0");

    // Swap write coincident with sop: this frame keeps bank 0.
    snk_valid = 1'b1; snk_sop = 1'b1; snk_channel = 9'd5; snk_data = 16'sd1000;
    avs_address = CTRL; avs_writedata = 32'h1; avs_write = 1'b1;
    cyc();
    snk_valid = 1'b0; snk_sop = 1'b0; avs_write = 1'b0;
    cyc();
    cyc();
    #4 chk("coincident sop data", {16'h0, src_data}, {16'h0, 16'sd500});
    cyc();
    av_rd(STATUS, 32'h2, "status coincident pending");
    av_wr(CTRL, 32'h1, 4'hF);
    send1(9'd5, 16'sd1000, 1'b1, 16'sd1000, "deferred swap");
    av_rd(STATUS, 32'h1, "status single toggle");
    send1(9'd5, 16'sd1000, 1'b1, 16'sd1000, "no second swap");

    av_wr(CTRL, 32'h2, 4'hF);
    send1(9'd7, 16'sd101, 1'b0, 16'sd101, "bypass");
    av_rd(STATUS, 32'h5, "status bypass");
    av_rd(CTRL, 32'h2, "ctrl readback");
    av_wr(CTRL, 32'h0, 4'hF);

    av_wr(10'd3, 32'h0, 4'hF);
    av_wr(10'd3, 32'hDEAD_BEEF, 4'h3);
    av_rd(10'd3, 32'h0000_BEEF, "byteenable readback");
    av_rd(10'd5, 32'h0000_2000, "shadow ch5 readback");
    av_wr(10'd330, 32'h1234_5678, 4'hF);
    av_rd(10'd330, 32'h0, "out of range read");

    // Reset in the middle of a stream.
    snk_valid = 1'b1; snk_sop = 1'b0; snk_channel = 9'd5; snk_data = 16'sd1000;
    cyc();
    cyc();
    cyc();
    #3 rst_ni = 1'b0;
    #1 chk("mid reset src_valid", {31'b0, src_valid}, 32'd0);
    chk("mid reset src_data", {16'h0, src_data}, 32'd0);
    snk_valid = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #4 if (src_valid) stale = 1'b1;
      cyc();
    end
    chk("no stale output", {31'b0, stale}, 32'd0);
    av_rd(STATUS, 32'h0, "status after mid reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
